// File: rtl/rotor_load_ctrl.sv
// Purpose : front-end sequencer for the rotor datapath. It streams DEPTH codes into each of
//           NUM_TABLES rotor tables in turn, then forwards plaintext and issues rotor-step pulses.
// Latency : 1 cycle from accept to the load / crypt_valid pulse, at one accept per cycle with no bubbles.
// Backpressure: in_ready is combinational and drops on stall, reload or rst. Pulses that are
//           already registered still appear on the next cycle.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset (rst has priority)
//   in_valid/in_code   input stream: table entries while loading, plaintext in RUN
//   in_ready           in_code is taken this cycle when in_valid is also high
//   stall              downstream back-pressure, gates acceptance only
//   reload             one-cycle request to restart loading from table A
//   table_idx          table the current load pulse belongs to; 2'b11 once in RUN
//   load               one-cycle pulse per accepted table entry
//   code_out           code accompanying load or crypt_valid
//   crypt_valid        one-cycle pulse per accepted RUN character
//   rotA_shift         rotor A steps after this character
//   rotB_shift         rotor B steps after this character (every DEPTH-th character)
//   loaded             high while in RUN
module rotor_load_ctrl #(
    parameter int DEPTH      = 64,
    parameter int NUM_TABLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [5:0] in_code,
    output logic       in_ready,
    input  logic       stall,
    input  logic       reload,
    output logic [1:0] table_idx,
    output logic       load,
    output logic [5:0] code_out,
    output logic       crypt_valid,
    output logic       rotA_shift,
    output logic       rotB_shift,
    output logic       loaded
);

    localparam int         CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_ENT = CW'(DEPTH - 1);
    localparam logic [1:0]    LAST_TBL = 2'(NUM_TABLES - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    tbl_cnt;
    logic [CW-1:0] ent_cnt;
    logic [CW-1:0] step_cnt;
    logic          accept;

    assign in_ready = !stall && !reload && !rst;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            tbl_cnt     <= '0;
            ent_cnt     <= '0;
            step_cnt    <= '0;
            table_idx   <= 2'b00;
            load        <= 1'b0;
            code_out    <= '0;
            crypt_valid <= 1'b0;
            rotA_shift  <= 1'b0;
            rotB_shift  <= 1'b0;
            loaded      <= 1'b0;
        end else if (reload) begin
            // code_out is left holding; only the pulses and the progress are cleared
            state       <= S_LOAD;
            tbl_cnt     <= '0;
            ent_cnt     <= '0;
            step_cnt    <= '0;
            table_idx   <= 2'b00;
            load        <= 1'b0;
            crypt_valid <= 1'b0;
            rotA_shift  <= 1'b0;
            rotB_shift  <= 1'b0;
            loaded      <= 1'b0;
        end else begin
            load        <= 1'b0;
            crypt_valid <= 1'b0;
            rotA_shift  <= 1'b0;
            rotB_shift  <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        // table_idx is taken from the table counter of this entry, so the
                        // switch to the next table happens on that table's first pulse,
                        // and never on an idle cycle
                        load      <= 1'b1;
                        table_idx <= tbl_cnt;
                        code_out  <= in_code;
                        if (ent_cnt == LAST_ENT) begin
                            ent_cnt <= '0;
                            tbl_cnt <= tbl_cnt + 2'd1;
                            if (tbl_cnt == LAST_TBL) begin
                                state <= S_RUN;
                            end
                        end else begin
                            ent_cnt <= ent_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // First RUN cycle follows the final load pulse, even without an accept
                    table_idx <= 2'b11;
                    loaded    <= 1'b1;
                    if (accept) begin
                        crypt_valid <= 1'b1;
                        code_out    <= in_code;
                        rotA_shift  <= 1'b1;
                        rotB_shift  <= (step_cnt == LAST_ENT);
                        step_cnt    <= (step_cnt == LAST_ENT) ? '0 : step_cnt + 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_load_ctrl.sv
module tb_rotor_load_ctrl;

    logic       clk = 1'b0;
    logic       rst, in_valid, stall, reload;
    logic [5:0] in_code;
    logic       in_ready, load, crypt_valid, rotA_shift, rotB_shift, loaded;
    logic [1:0] table_idx;
    logic [5:0] code_out;

    int checks = 0;
    int errors = 0;

    rotor_load_ctrl #(.DEPTH(64), .NUM_TABLES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .in_ready    (in_ready),
        .stall       (stall),
        .reload      (reload),
        .table_idx   (table_idx),
        .load        (load),
        .code_out    (code_out),
        .crypt_valid (crypt_valid),
        .rotA_shift  (rotA_shift),
        .rotB_shift  (rotB_shift),
        .loaded      (loaded)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs applied before the edge, expected outputs after it.
    // e_rdy is the expected combinational in_ready for the applied inputs.
    typedef struct {
        logic       r, v, s, rl;
        logic [5:0] c;
        logic       e_load;
        logic [1:0] e_idx;
        logic [5:0] e_code;
        logic       e_cv, e_a, e_b, e_loaded, e_rdy;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic r, v, input logic [5:0] c,
                       input logic s, rl, input logic el, input logic [1:0] ei,
                       input logic [5:0] ec, input logic ecv, ea, eb, eld, erdy);
        vec_t x;
        x.tag = tag; x.r = r; x.v = v; x.c = c; x.s = s; x.rl = rl;
        x.e_load = el; x.e_idx = ei; x.e_code = ec; x.e_cv = ecv;
        x.e_a = ea; x.e_b = eb; x.e_loaded = eld; x.e_rdy = erdy;
        vecs.push_back(x);
    endtask

    // Accepted table entry: its code is the entry number within the table
    task automatic add_load(input string tag, input int tbl, input int ent);
        add(tag, 0, 1, 6'(ent), 0, 0, 1, 2'(tbl), 6'(ent), 0, 0, 0, 0, 1);
    endtask

    // Idle load-phase cycle: idx and code hold
    task automatic add_idle_load(input string tag, input int tbl, input int held);
        add(tag, 0, 0, 6'h2A, 0, 0, 0, 2'(tbl), 6'(held), 0, 0, 0, 0, 1);
    endtask

    task automatic add_table(input string tag, input int tbl, input int first, input int last);
        for (int e = first; e <= last; e++) add_load(tag, tbl, e);
    endtask

    function automatic logic [5:0] rc(input int j);
        return 6'((j * 7 + 3) % 64);
    endfunction

    // j counts characters from 0 since entering RUN; rotor B steps on every 64th
    task automatic add_run(input string tag, input int j);
        add(tag, 0, 1, rc(j), 0, 0, 0, 2'b11, rc(j), 1, 1, ((j % 64) == 63), 1, 1);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [vec %0d %s]: got %0h expected %0h", name, idx, vecs[idx].tag, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; stall = 1'b0; reload = 1'b0;

        // Reset, rst has priority over a valid input
        add("reset", 1, 1, 6'h05, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
        add("reset", 1, 1, 6'h06, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
        add_idle_load("idle0", 0, 0);

        // Full back-to-back load, then straight into 130 RUN characters
        for (int t = 0; t < 3; t++) add_table("load1", t, 0, 63);
        for (int j = 0; j < 130; j++) add_run("run1", j);
        add("run_idle", 0, 0, 6'h11, 0, 0, 0, 2'b11, rc(129), 0, 0, 0, 1, 1);

        // Reload from RUN: input refused, back to table A
        add("reload1", 0, 1, 6'h09, 0, 1, 0, 2'b00, rc(129), 0, 0, 0, 0, 0);

        // Stall for 5 cycles in the middle of table B
        add_table("load2", 0, 0, 63);
        add_table("load2", 1, 0, 19);
        for (int k = 0; k < 5; k++)
            add("stall", 0, 1, 6'h3F, 1, 0, 0, 2'b01, 6'd19, 0, 0, 0, 0, 0);
        add_table("load2", 1, 20, 63);
        add_table("load2", 2, 0, 63);
        for (int j = 0; j < 40; j++) add_run("run2", j);
        add("reload2", 0, 1, 6'h05, 0, 1, 0, 2'b00, rc(39), 0, 0, 0, 0, 0);

        // Reload restarts the step count; valid toggles across the B->C boundary
        add_table("load3", 0, 0, 63);
        add_table("load3", 1, 0, 59);
        for (int e = 60; e < 64; e++) begin
            add_load("toggleB", 1, e);
            add_idle_load("toggleB", 1, e);
        end
        for (int e = 0; e < 4; e++) begin
            add_load("toggleC", 2, e);
            add_idle_load("toggleC", 2, e);
        end
        add_table("load3", 2, 4, 63);
        for (int j = 0; j < 64; j++) add_run("run3", j);

        // rst in the middle of table C discards all progress
        add("reload3", 0, 0, 6'h00, 0, 1, 0, 2'b00, rc(63), 0, 0, 0, 0, 0);
        add_table("load4", 0, 0, 63);
        add_table("load4", 1, 0, 63);
        add_table("load4", 2, 0, 29);
        add("rst_midC", 1, 1, 6'h07, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0, 0, 0);
        add_table("load5", 0, 0, 63);
        add_table("load5", 1, 0, 1);
        add_idle_load("idle5", 1, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst      = vecs[i].r;
            in_valid = vecs[i].v;
            in_code  = vecs[i].c;
            stall    = vecs[i].s;
            reload   = vecs[i].rl;
            #1;
            chk("in_ready", i, int'(in_ready), int'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk("load",        i, int'(load),        int'(vecs[i].e_load));
            chk("table_idx",   i, int'(table_idx),   int'(vecs[i].e_idx));
            chk("code_out",    i, int'(code_out),    int'(vecs[i].e_code));
            chk("crypt_valid", i, int'(crypt_valid), int'(vecs[i].e_cv));
            chk("rotA_shift",  i, int'(rotA_shift),  int'(vecs[i].e_a));
            chk("rotB_shift",  i, int'(rotB_shift),  int'(vecs[i].e_b));
            chk("loaded",      i, int'(loaded),      int'(vecs[i].e_loaded));
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
